// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
// Holds the RV32I opcodes the controller decodes, the PC-mux and forwarding
// select encodings, the NOP instruction word, the controller state type and
// small opcode-classification helpers used by the forwarding compare.
package pipeline_ctrl_pkg;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_ALU  = 2'b01;
    localparam logic [1:0] PC_SEL_JALR = 2'b10;
    localparam logic [1:0] PC_SEL_HOLD = 2'b11;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_ALU  = 2'b01;
    localparam logic [1:0] FWD_LOAD = 2'b10;
    localparam logic [1:0] FWD_PC4  = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] INSN_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_STALL = 2'd3
    } ctrl_state_t;

    // Where an s3 instruction's rd value comes from; FWD_RF means it
    // does not write rd at all and can never be a forwarding source.
    function automatic logic [1:0] fwd_source(input logic [6:0] opc);
        case (opc)
            OPC_ARI_RTYPE, OPC_ARI_ITYPE,
            OPC_LUI, OPC_AUIPC:      return FWD_ALU;
            OPC_LOAD:                return FWD_LOAD;
            OPC_JAL, OPC_JALR:       return FWD_PC4;
            default:                 return FWD_RF;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_ARI_RTYPE) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// s3 -> s2 forwarding compare (purely combinational).
// Ports:
//   instruction_s2  in  32  instruction currently in decode/execute
//   instruction_s3  in  32  instruction currently in memory/writeback
//   s3_valid        in  1   s3 holds a real instruction
//   forward_sel_1   out 2   rs1 operand source
//   forward_sel_2   out 2   rs2 operand source
module pipeline_ctrl_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [31:0] instruction_s2,
    input  logic [31:0] instruction_s3,
    input  logic        s3_valid,
    output logic [1:0]  forward_sel_1,
    output logic [1:0]  forward_sel_2
);

    logic [6:0] opc_s2;
    logic [6:0] opc_s3;
    logic [4:0] rs1_s2;
    logic [4:0] rs2_s2;
    logic [4:0] rd_s3;
    logic [1:0] src_s3;
    logic       s3_live;

    assign opc_s2 = instruction_s2[6:0];
    assign rs1_s2 = instruction_s2[19:15];
    assign rs2_s2 = instruction_s2[24:20];
    assign opc_s3 = instruction_s3[6:0];
    assign rd_s3  = instruction_s3[11:7];

    assign src_s3 = fwd_source(opc_s3);

    // x0 is hard-wired to zero, so a write to it is never a real producer.
    assign s3_live = s3_valid && (rd_s3 != 5'd0) && (src_s3 != FWD_RF);

    assign forward_sel_1 = (s3_live && uses_rs1(opc_s2) && (rs1_s2 == rd_s3)) ? src_s3 : FWD_RF;
    assign forward_sel_2 = (s3_live && uses_rs2(opc_s2) && (rs2_s2 == rd_s3)) ? src_s3 : FWD_RF;

    // Instruction fields this compare does not look at.
    logic unused_fields;
    assign unused_fields = ^{instruction_s2[31:25], instruction_s2[14:7], instruction_s3[31:12]};

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 3-stage core (IF / DX / MWB).
// Handles the post-reset fetch hold, control-flow redirect and wrong-path
// flush, I/O stall freeze, s3->s2 forwarding selects and the cycle /
// retired-instruction performance counters.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   instruction_s2/_s3             instructions in s2 and s3
//   s3_valid                       s3 holds a real instruction
//   br_taken                       branch compare result for s2
//   io_stall                       freeze whole pipeline
//   cnt_clear                      zero both performance counters
//   pc_sel                         PC mux select
//   s1_en, s2_en                   pipeline register enables
//   kill_s2                        load NOP into s2 at next edge
//   forward_sel_1/_2               rs1/rs2 operand source selects
//   cycle_cnt, instret_cnt         performance counters
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction_s2,
    input  logic [31:0]      instruction_s3,
    input  logic             s3_valid,
    input  logic             br_taken,
    input  logic             io_stall,
    input  logic             cnt_clear,
    output logic [1:0]       pc_sel,
    output logic             s1_en,
    output logic             s2_en,
    output logic             kill_s2,
    output logic [1:0]       forward_sel_1,
    output logic [1:0]       forward_sel_2,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    ctrl_state_t state, next_state;
    ctrl_state_t resume_state, next_resume;
    ctrl_state_t eff_state;
    logic [HW-1:0] hold_cnt, next_hold;
    logic [1:0]    flush_cnt, next_flush;

    logic [6:0] opc_s2;
    logic       redirect_alu;
    logic       redirect_jalr;

    assign opc_s2        = instruction_s2[6:0];
    assign redirect_alu  = (opc_s2 == OPC_JAL) || ((opc_s2 == OPC_BRANCH) && br_taken);
    assign redirect_jalr = (opc_s2 == OPC_JALR);

    // While stalled, the pipeline behaves as the interrupted state as soon
    // as io_stall drops, so leaving STALL costs no extra bubble and a
    // redirect waiting in s2 is taken on that very cycle.
    assign eff_state = (state == ST_STALL) ? resume_state : state;

    always_comb begin
        pc_sel      = PC_SEL_PC4;
        s1_en       = 1'b1;
        s2_en       = 1'b1;
        kill_s2     = 1'b0;
        next_state  = state;
        next_resume = resume_state;
        next_hold   = hold_cnt;
        next_flush  = flush_cnt;

        if (state == ST_HOLD) begin
            pc_sel  = PC_SEL_HOLD;
            s1_en   = 1'b0;
            s2_en   = 1'b0;
            kill_s2 = 1'b1;
            if (hold_cnt == '0) begin
                next_state = ST_RUN;
            end else begin
                next_hold = hold_cnt - HW'(1);
            end
        end else if (io_stall) begin
            // Stall outranks redirect; flush_cnt is left untouched so a
            // partially drained flush resumes where it stopped.
            pc_sel      = PC_SEL_HOLD;
            s1_en       = 1'b0;
            s2_en       = 1'b0;
            next_state  = ST_STALL;
            next_resume = eff_state;
        end else if (eff_state == ST_FLUSH) begin
            kill_s2 = 1'b1;
            if (flush_cnt == 2'd0) begin
                next_state = ST_RUN;
            end else begin
                next_state = ST_FLUSH;
                next_flush = flush_cnt - 2'd1;
            end
        end else begin
            next_state = ST_RUN;
            if (redirect_alu || redirect_jalr) begin
                pc_sel     = redirect_jalr ? PC_SEL_JALR : PC_SEL_ALU;
                kill_s2    = 1'b1;
                next_state = ST_FLUSH;
                next_flush = 2'(FLUSH_CYCLES - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_HOLD;
            resume_state <= ST_RUN;
            hold_cnt     <= HW'(HOLD_CYCLES - 1);
            flush_cnt    <= 2'd0;
            cycle_cnt    <= '0;
            instret_cnt  <= '0;
        end else begin
            state        <= next_state;
            resume_state <= next_resume;
            hold_cnt     <= next_hold;
            flush_cnt    <= next_flush;
            if (cnt_clear) begin
                cycle_cnt   <= '0;
                instret_cnt <= '0;
            end else if (state != ST_HOLD) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (s3_valid && !io_stall) begin
                    instret_cnt <= instret_cnt + CNT_W'(1);
                end
            end
        end
    end

    pipeline_ctrl_fwd_unit u_fwd (
        .instruction_s2 (instruction_s2),
        .instruction_s3 (instruction_s3),
        .s3_valid       (s3_valid),
        .forward_sel_1  (forward_sel_1),
        .forward_sel_2  (forward_sel_2)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a behavioural model of the controller.
module tb_pipeline_ctrl;

    localparam int HOLD_CYCLES  = 2;
    localparam int FLUSH_CYCLES = 1;
    localparam int CNT_W        = 8;
    localparam int CNT_MOD      = 1 << CNT_W;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_I = 7'b0010011, OP_R = 7'b0110011;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      instruction_s2, instruction_s3;
    logic             s3_valid, br_taken, io_stall, cnt_clear;
    logic [1:0]       pc_sel, forward_sel_1, forward_sel_2;
    logic             s1_en, s2_en, kill_s2;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;
    logic [4:0]       ctl;
    logic [3:0]       fwd;

    assign ctl = {pc_sel, s1_en, s2_en, kill_s2};
    assign fwd = {forward_sel_1, forward_sel_2};

    pipeline_ctrl #(.HOLD_CYCLES(HOLD_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .instruction_s2(instruction_s2), .instruction_s3(instruction_s3),
        .s3_valid(s3_valid), .br_taken(br_taken), .io_stall(io_stall), .cnt_clear(cnt_clear),
        .pc_sel(pc_sel), .s1_en(s1_en), .s2_en(s2_en), .kill_s2(kill_s2),
        .forward_sel_1(forward_sel_1), .forward_sel_2(forward_sel_2),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: cycles of fetch hold left, wrong-path kills left,
    // and the two counters as plain integers.
    int m_hold  = HOLD_CYCLES;
    int m_flush = 0;
    int m_cyc   = 0;
    int m_ins   = 0;

    // 0: no redirect, 1: to s2 ALU target, 2: to JALR target
    function automatic int redirect_kind(input logic [31:0] ins, input logic taken);
        if (ins[6:0] == OP_JAL) return 1;
        if (ins[6:0] == OP_JALR) return 2;
        if (ins[6:0] == OP_BR && taken) return 1;
        return 0;
    endfunction

    function automatic logic [4:0] model_ctl();
        if (m_hold > 0) return 5'b11_0_0_1;
        if (io_stall) return 5'b11_0_0_0;
        if (m_flush > 0) return 5'b00_1_1_1;
        case (redirect_kind(instruction_s2, br_taken))
            1: return 5'b01_1_1_1;
            2: return 5'b10_1_1_1;
            default: return 5'b00_1_1_0;
        endcase
    endfunction

    function automatic logic [3:0] model_fwd(input logic [31:0] s2, input logic [31:0] s3, input logic v);
        logic [6:0] o2, o3;
        logic [4:0] rd;
        logic [1:0] src, f1, f2;
        logic live;
        o2 = s2[6:0];
        o3 = s3[6:0];
        rd = s3[11:7];
        live = v && (rd != 0) && (o3 inside {OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR});
        src = (o3 == OP_LOAD) ? 2'b10 : ((o3 == OP_JAL || o3 == OP_JALR) ? 2'b11 : 2'b01);
        f1 = (live && !(o2 inside {OP_LUI, OP_AUIPC, OP_JAL}) && s2[19:15] == rd) ? src : 2'b00;
        f2 = (live && (o2 inside {OP_R, OP_STORE, OP_BR}) && s2[24:20] == rd) ? src : 2'b00;
        return {f1, f2};
    endfunction

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_hold = HOLD_CYCLES; m_flush = 0; m_cyc = 0; m_ins = 0;
        end else begin
            if (cnt_clear) begin
                m_cyc = 0; m_ins = 0;
            end else if (m_hold == 0) begin
                m_cyc = (m_cyc + 1) % CNT_MOD;
                if (s3_valid && !io_stall) m_ins = (m_ins + 1) % CNT_MOD;
            end
            if (m_hold > 0) m_hold--;
            else if (!io_stall) begin
                if (m_flush > 0) m_flush--;
                else if (redirect_kind(instruction_s2, br_taken) != 0) m_flush = FLUSH_CYCLES;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        instruction_s2 = NOP; instruction_s3 = NOP;
        s3_valid = 0; br_taken = 0; io_stall = 0; cnt_clear = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        repeat (3) advance();
        @(negedge clk);
        n_checks++; if (ctl !== 5'b11_0_0_1) begin n_fails++; $display("FAIL reset_ctl got %b exp %b", ctl, 5'b11001); end
        n_checks++; if (fwd !== 4'b0000) begin n_fails++; $display("FAIL reset_fwd got %b exp 0000", fwd); end
        n_checks++; if (cycle_cnt !== 0 || instret_cnt !== 0) begin n_fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        advance();
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (ctl !== 5'b11_0_0_1) begin n_fails++; $display("FAIL hold_ctl[%0d] got %b exp %b", i, ctl, 5'b11001); end
            advance();
        end
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_0) begin n_fails++; $display("FAIL run_entry got %b exp %b", ctl, 5'b00110); end
        n_checks++; if (cycle_cnt !== 0) begin n_fails++; $display("FAIL run_entry_cyc got %0d exp 0", cycle_cnt); end
        advance();
        @(negedge clk);
        n_checks++; if (cycle_cnt !== 1) begin n_fails++; $display("FAIL first_cyc got %0d exp 1", cycle_cnt); end
        advance();
    endtask

    task automatic test_branch_flush();
        instruction_s2 = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, OP_BR}; // beq x1,x2
        br_taken = 0;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_0) begin n_fails++; $display("FAIL br_not_taken got %b exp %b", ctl, 5'b00110); end
        advance();
        br_taken = 1;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b01_1_1_1) begin n_fails++; $display("FAIL br_taken got %b exp %b", ctl, 5'b01111); end
        advance();
        instruction_s2 = NOP; br_taken = 0;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_1) begin n_fails++; $display("FAIL br_flush got %b exp %b", ctl, 5'b00111); end
        advance();
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_0) begin n_fails++; $display("FAIL br_resume got %b exp %b", ctl, 5'b00110); end
        advance();
    endtask

    task automatic test_jalr_stall();
        instruction_s2 = {12'd0, 5'd5, 3'b000, 5'd1, OP_JALR}; // jalr x1,0(x5)
        io_stall = 1; s3_valid = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (ctl !== 5'b11_0_0_0) begin n_fails++; $display("FAIL stall_ctl[%0d] got %b exp %b", i, ctl, 5'b11000); end
            advance();
        end
        io_stall = 0;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b10_1_1_1) begin n_fails++; $display("FAIL jalr_after_stall got %b exp %b", ctl, 5'b10111); end
        n_checks++; if (instret_cnt !== m_ins[CNT_W-1:0] || cycle_cnt !== m_cyc[CNT_W-1:0]) begin
            n_fails++; $display("FAIL stall_cnt got %0d/%0d exp %0d/%0d", cycle_cnt, instret_cnt, m_cyc, m_ins); end
        advance();
        instruction_s2 = NOP; s3_valid = 0;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_1) begin n_fails++; $display("FAIL jalr_flush got %b exp %b", ctl, 5'b00111); end
        advance();
    endtask

    task automatic test_forwarding();
        logic [31:0] s2v [8];
        logic [31:0] s3v [8];
        logic        vv  [8];
        logic [3:0]  ev  [8];
        s3v[0] = {12'd0, 5'd1, 3'b010, 5'd5, OP_LOAD};  s2v[0] = {7'd0, 5'd5, 5'd5, 3'b000, 5'd6, OP_R}; vv[0] = 1; ev[0] = 4'b1010;
        s3v[1] = {12'd0, 5'd1, 3'b010, 5'd0, OP_LOAD};  s2v[1] = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, OP_R}; vv[1] = 1; ev[1] = 4'b0000;
        s3v[2] = {20'd0, 5'd1, OP_JAL};                 s2v[2] = {12'd4, 5'd1, 3'b000, 5'd2, OP_I};      vv[2] = 1; ev[2] = 4'b1100;
        s3v[3] = {12'd1, 5'd0, 3'b000, 5'd7, OP_I};     s2v[3] = {7'd0, 5'd7, 5'd7, 3'b010, 5'd0, OP_STORE}; vv[3] = 1; ev[3] = 4'b0101;
        s3v[4] = s3v[0];                                s2v[4] = s2v[0];                                vv[4] = 0; ev[4] = 4'b0000;
        s3v[5] = {20'd5, 5'd3, OP_LUI};                 s2v[5] = {12'd0, 5'd3, 3'd0, 5'd4, OP_LUI};     vv[5] = 1; ev[5] = 4'b0000;
        s3v[6] = {7'd0, 5'd5, 5'd1, 3'b010, 5'd6, OP_STORE}; s2v[6] = {7'd0, 5'd6, 5'd6, 3'b000, 5'd6, OP_R}; vv[6] = 1; ev[6] = 4'b0000;
        s3v[7] = {7'd0, 5'd2, 5'd3, 3'b000, 5'd5, OP_R}; s2v[7] = {7'd0, 5'd5, 5'd1, 3'b000, 5'd8, OP_BR}; vv[7] = 1; ev[7] = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            instruction_s2 = s2v[i]; instruction_s3 = s3v[i]; s3_valid = vv[i];
            @(negedge clk);
            n_checks++; if (fwd !== ev[i]) begin n_fails++; $display("FAIL fwd_case[%0d] got %b exp %b", i, fwd, ev[i]); end
            advance();
        end
        idle_inputs();
    endtask

    task automatic test_counters();
        cnt_clear = 1;
        advance();
        cnt_clear = 0; s3_valid = 1;
        @(negedge clk);
        n_checks++; if (cycle_cnt !== 0 || instret_cnt !== 0) begin n_fails++; $display("FAIL clear got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        repeat (10) advance();
        cnt_clear = 1;
        @(negedge clk);
        n_checks++; if (instret_cnt !== 10 || cycle_cnt !== 10) begin n_fails++; $display("FAIL ten_retired got %0d/%0d exp 10/10", cycle_cnt, instret_cnt); end
        advance();
        cnt_clear = 0; s3_valid = 0;
        @(negedge clk);
        n_checks++; if (instret_cnt !== 0 || cycle_cnt !== 0) begin n_fails++; $display("FAIL clear_overrides got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        cnt_clear = 1;
        advance();
        cnt_clear = 0; s3_valid = 1;
        repeat (CNT_MOD - 1) advance();
        @(negedge clk);
        n_checks++; if (cycle_cnt !== CNT_W'(CNT_MOD - 1) || instret_cnt !== CNT_W'(CNT_MOD - 1)) begin
            n_fails++; $display("FAIL cnt_max got %0d/%0d exp %0d", cycle_cnt, instret_cnt, CNT_MOD - 1); end
        advance();
        @(negedge clk);
        n_checks++; if (cycle_cnt !== 0 || instret_cnt !== 0) begin n_fails++; $display("FAIL cnt_wrap got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        advance();
        s3_valid = 0;
    endtask

    task automatic test_rst_in_flush();
        instruction_s2 = {20'd8, 5'd1, OP_JAL};
        @(negedge clk);
        n_checks++; if (ctl !== 5'b01_1_1_1) begin n_fails++; $display("FAIL jal_redirect got %b exp %b", ctl, 5'b01111); end
        advance();
        instruction_s2 = NOP; rst = 1;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_1) begin n_fails++; $display("FAIL pre_rst_flush got %b exp %b", ctl, 5'b00111); end
        advance();
        rst = 0;
        @(negedge clk);
        n_checks++; if (ctl !== 5'b11_0_0_1 || fwd !== 4'b0000) begin n_fails++; $display("FAIL rst_flush_ctl got %b/%b exp 11001/0000", ctl, fwd); end
        n_checks++; if (cycle_cnt !== 0 || instret_cnt !== 0) begin n_fails++; $display("FAIL rst_flush_cnt got %0d/%0d exp 0/0", cycle_cnt, instret_cnt); end
        repeat (2) advance();
        @(negedge clk);
        n_checks++; if (ctl !== 5'b00_1_1_0) begin n_fails++; $display("FAIL rst_flush_run got %b exp %b", ctl, 5'b00110); end
        advance();
    endtask

    function automatic logic [6:0] pick_op(input int k);
        case (k)
            0: return OP_LUI;   1: return OP_AUIPC; 2: return OP_JAL;
            3: return OP_JALR;  4: return OP_BR;    5: return OP_LOAD;
            6: return OP_STORE; 7: return OP_I;     default: return OP_R;
        endcase
    endfunction

    function automatic logic [31:0] rand_insn();
        logic [31:0] w;
        w = $urandom;
        w[6:0]   = pick_op($urandom_range(0, 8));
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic test_random();
        logic [4:0] ec;
        logic [3:0] ef;
        for (int i = 0; i < 800; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            io_stall       = ($urandom_range(0, 4) == 0);
            cnt_clear      = ($urandom_range(0, 31) == 0);
            s3_valid       = 1'($urandom_range(0, 1));
            br_taken       = 1'($urandom_range(0, 1));
            instruction_s2 = rand_insn();
            instruction_s3 = rand_insn();
            @(negedge clk);
            ec = model_ctl();
            ef = model_fwd(instruction_s2, instruction_s3, s3_valid);
            n_checks++; if (ctl !== ec) begin n_fails++; $display("FAIL rand_ctl[%0d] got %b exp %b", i, ctl, ec); end
            n_checks++; if (fwd !== ef) begin n_fails++; $display("FAIL rand_fwd[%0d] got %b exp %b", i, fwd, ef); end
            n_checks++; if (cycle_cnt !== m_cyc[CNT_W-1:0] || instret_cnt !== m_ins[CNT_W-1:0]) begin
                n_fails++; $display("FAIL rand_cnt[%0d] got %0d/%0d exp %0d/%0d", i, cycle_cnt, instret_cnt, m_cyc, m_ins); end
            advance();
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_branch_flush();
        test_jalr_stall();
        test_forwarding();
        test_counters();
        test_rst_in_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
